// File: rtl/s420_scan_ctrl_pkg.sv
// Shared types and default widths for the s420 scan controller.
package s420_scan_pkg;

    localparam int DEF_SEL_W = 17;
    localparam int DEF_LEN_W = 16;
    localparam int DEF_HIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } scan_state_t;

    typedef enum logic [1:0] {
        STATUS_LEN_DONE  = 2'b00,
        STATUS_HIT_LIMIT = 2'b01,
        STATUS_ABORTED   = 2'b10
    } scan_status_t;

endpackage

// File: rtl/s420_scan_ctrl_if.sv
// Command, datapath and response bundle of the s420 scan controller.
// The slave modport is the controller; the master modport is whoever issues
// scans and models the counter/compare datapath.
interface s420_scan_ctrl_if
    import s420_scan_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int HIT_W = DEF_HIT_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_sel;
    logic [LEN_W-1:0] cmd_len;
    logic [HIT_W-1:0] cmd_hitlim;
    logic             abort;
    logic             dp_en;
    logic [SEL_W-1:0] dp_sel;
    logic             dp_hit;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [HIT_W-1:0] rsp_hits;
    logic [LEN_W-1:0] rsp_cycles;
    logic [1:0]       rsp_status;
    logic             busy;

    modport master (
        output cmd_valid, cmd_sel, cmd_len, cmd_hitlim, abort, dp_hit, rsp_ready,
        input  cmd_ready, dp_en, dp_sel, rsp_valid, rsp_hits, rsp_cycles, rsp_status, busy
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_len, cmd_hitlim, abort, dp_hit, rsp_ready,
        output cmd_ready, dp_en, dp_sel, rsp_valid, rsp_hits, rsp_cycles, rsp_status, busy
    );

endinterface

// File: rtl/s420_scan_ctrl.sv
// Scan controller: accepts a scan command, drives the datapath count enable
// for the requested number of cycles, counts compare hits and reports how the
// scan ended (length reached, hit limit reached, or aborted).
module s420_scan_ctrl
    import s420_scan_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int HIT_W = DEF_HIT_W
) (
    input logic          CK,
    input logic          RST_N,
    s420_scan_ctrl_if.slave bus
);

    scan_state_t      state;
    scan_status_t     status_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             run_q;
    logic             rsp_valid_q;
    logic [SEL_W-1:0] dp_sel_q;
    logic [LEN_W-1:0] len_q;
    logic [HIT_W-1:0] hitlim_q;
    logic [LEN_W-1:0] cyc_q;
    logic [HIT_W-1:0] hit_q;

    logic [LEN_W-1:0] cyc_inc;
    logic [HIT_W-1:0] hit_inc;
    logic             hit_stop;
    logic             len_stop;

    // Counter values this RUN cycle would produce; the hit count sticks at all-ones.
    assign cyc_inc  = cyc_q + LEN_W'(1);
    assign hit_inc  = (bus.dp_hit && (hit_q != {HIT_W{1'b1}})) ? hit_q + HIT_W'(1) : hit_q;
    assign hit_stop = (hitlim_q != '0) && (hit_inc == hitlim_q);
    assign len_stop = (cyc_inc == len_q);

    // Scan sequencing, command capture, counters and all registered outputs.
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            status_q    <= STATUS_LEN_DONE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            dp_sel_q    <= '0;
            len_q       <= '0;
            hitlim_q    <= '0;
            cyc_q       <= '0;
            hit_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        state       <= ST_LOAD;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        dp_sel_q    <= bus.cmd_sel;
                        len_q       <= bus.cmd_len;
                        hitlim_q    <= bus.cmd_hitlim;
                        cyc_q       <= '0;
                        hit_q       <= '0;
                        status_q    <= STATUS_LEN_DONE;
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        state       <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        status_q    <= STATUS_ABORTED;
                    end else if (len_q == '0) begin
                        state       <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        status_q    <= STATUS_LEN_DONE;
                    end else begin
                        state <= ST_RUN;
                        run_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state       <= ST_DONE;
                        run_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        status_q    <= STATUS_ABORTED;
                    end else begin
                        cyc_q <= cyc_inc;
                        hit_q <= hit_inc;
                        if (hit_stop || len_stop) begin
                            state       <= ST_DONE;
                            run_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            status_q    <= hit_stop ? STATUS_HIT_LIMIT : STATUS_LEN_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.dp_en      = run_q & ~bus.abort;
    assign bus.dp_sel     = dp_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hits   = hit_q;
    assign bus.rsp_cycles = cyc_q;
    assign bus.rsp_status = status_q;

endmodule

// File: tb/tb_s420_scan_ctrl.sv
// Self-checking bench for s420_scan_ctrl: a transaction-level model predicts
// each scan's outcome, per-cycle expectations are derived from it, and one
// compare process checks the DUT on every falling clock edge.
module tb_s420_scan_ctrl;

    localparam int SEL_W = 17;
    localparam int LEN_W = 16;
    localparam int HIT_W = 8;
    localparam int HIT_MAX = (1 << HIT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int failures = 0;

    logic             chk_en = 1'b0;
    logic             exp_cmd_ready;
    logic             exp_busy;
    logic             exp_dp_en;
    logic             exp_rsp_valid;
    logic             exp_rsp_chk;
    logic [SEL_W-1:0] exp_dp_sel;
    logic [HIT_W-1:0] exp_hits;
    logic [LEN_W-1:0] exp_cycles;
    logic [1:0]       exp_status;
    logic [SEL_W-1:0] prev_sel;
    logic             hit_seq [0:511];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    s420_scan_ctrl_if #(.SEL_W(SEL_W), .LEN_W(LEN_W), .HIT_W(HIT_W)) bus ();

    s420_scan_ctrl #(.SEL_W(SEL_W), .LEN_W(LEN_W), .HIT_W(HIT_W)) dut (
        .CK   (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_exp(input logic cr, input logic bz, input logic en,
                           input logic [SEL_W-1:0] sel, input logic rv);
        exp_cmd_ready = cr;
        exp_busy      = bz;
        exp_dp_en     = en;
        exp_dp_sel    = sel;
        exp_rsp_valid = rv;
    endtask

    task automatic set_rsp(input logic chk, input int h, input int c, input int s);
        exp_rsp_chk = chk;
        exp_hits    = h[HIT_W-1:0];
        exp_cycles  = c[LEN_W-1:0];
        exp_status  = s[1:0];
    endtask

    // Single compare point, away from the rising edge where the DUT updates.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, exp_cmd_ready});
            checkOutput("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
            checkOutput("dp_en", {31'b0, bus.dp_en}, {31'b0, exp_dp_en});
            checkOutput("dp_sel", {15'b0, bus.dp_sel}, {15'b0, exp_dp_sel});
            checkOutput("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_rsp_valid});
            if (exp_rsp_chk) begin
                checkOutput("rsp_hits", {24'b0, bus.rsp_hits}, {24'b0, exp_hits});
                checkOutput("rsp_cycles", {16'b0, bus.rsp_cycles}, {16'b0, exp_cycles});
                checkOutput("rsp_status", {30'b0, bus.rsp_status}, {30'b0, exp_status});
            end
        end
    end

    // One complete scan. abort_at: -1 none, -2 during LOAD, k = k-th RUN cycle.
    // hit_mode: 0 random, 1 always hit, 2 hit on enabled cycles 2 and 4.
    // reset_at >= 0 drops RST_N during that RUN cycle. d_* return the DUT response.
    task automatic applyStimulus(input logic [SEL_W-1:0] sel, input int len, input int hitlim,
                                 input int abort_at, input int hold, input int hit_mode,
                                 input int reset_at, output int d_hits, output int d_cycles,
                                 output int d_status);
        int m_hits;
        int m_cycles;
        int m_status;
        int run_cycles;

        for (int i = 0; i < 512; i++) begin
            case (hit_mode)
                1:       hit_seq[i] = 1'b1;
                2:       hit_seq[i] = (i == 1) || (i == 3);
                default: hit_seq[i] = 1'($urandom_range(1, 0));
            endcase
        end

        m_hits = 0;
        m_cycles = 0;
        m_status = 0;
        run_cycles = 0;
        if (abort_at == -2) begin
            m_status = 2;
        end else if (len != 0) begin
            for (int k = 0; k < 512; k++) begin
                run_cycles = k + 1;
                if (k == abort_at) begin
                    m_status = 2;
                    break;
                end
                m_cycles++;
                if (hit_seq[k] && m_hits < HIT_MAX) m_hits++;
                if (hitlim != 0 && m_hits == hitlim) begin
                    m_status = 1;
                    break;
                end
                if (m_cycles == len) begin
                    m_status = 0;
                    break;
                end
            end
        end

        d_hits = -1;
        d_cycles = -1;
        d_status = -1;

        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_sel    = sel;
        bus.cmd_len    = len[LEN_W-1:0];
        bus.cmd_hitlim = hitlim[HIT_W-1:0];
        bus.abort      = 1'($urandom_range(1, 0));
        bus.dp_hit     = 1'($urandom_range(1, 0));
        bus.rsp_ready  = 1'($urandom_range(1, 0));
        set_exp(1'b1, 1'b0, 1'b0, prev_sel, 1'b0);
        set_rsp(1'b0, 0, 0, 0);

        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_sel   = SEL_W'($urandom);
        bus.abort     = (abort_at == -2);
        bus.dp_hit    = 1'($urandom_range(1, 0));
        set_exp(1'b0, 1'b1, 1'b0, sel, 1'b0);
        prev_sel = sel;

        for (int k = 0; k < run_cycles; k++) begin
            @(posedge clk); #1;
            bus.abort  = (k == abort_at);
            bus.dp_hit = hit_seq[k];
            set_exp(1'b0, 1'b1, !bus.abort, sel, 1'b0);
            if (k == reset_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                bus.abort = 1'b0;
                prev_sel = '0;
                set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
                set_rsp(1'b1, 0, 0, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            bus.abort      = 1'($urandom_range(1, 0));
            bus.dp_hit     = 1'($urandom_range(1, 0));
            bus.cmd_valid  = 1'($urandom_range(1, 0));
            bus.cmd_sel    = SEL_W'($urandom);
            bus.cmd_len    = LEN_W'($urandom_range(5, 0));
            bus.rsp_ready  = (h == hold);
            set_exp(1'b0, 1'b1, 1'b0, sel, 1'b1);
            set_rsp(1'b1, m_hits, m_cycles, m_status);
            if (h == 0) begin
                @(negedge clk);
                d_hits   = int'(bus.rsp_hits);
                d_cycles = int'(bus.rsp_cycles);
                d_status = int'(bus.rsp_status);
            end
        end

        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.abort     = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, sel, 1'b0);
        set_rsp(1'b0, 0, 0, 0);
    endtask

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] time limit");
    end

    // Reset check, directed scans with literal expectations, then random scans.
    initial begin
        int h, c, s;
        int len, hitlim, abort_at, r;

        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_sel    = '0;
        bus.cmd_len    = '0;
        bus.cmd_hitlim = '0;
        bus.abort      = 1'b0;
        bus.dp_hit     = 1'b0;
        bus.rsp_ready  = 1'b0;
        prev_sel       = '0;

        @(posedge clk); #1;
        set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
        set_rsp(1'b1, 0, 0, 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(17'h12345, 5, 0, -1, 2, 2, -1, h, c, s);
        checkOutput("len5_hits", h, 2);
        checkOutput("len5_cycles", c, 5);
        checkOutput("len5_status", s, 0);

        applyStimulus(17'h0abcd, 100, 3, -1, 1, 1, -1, h, c, s);
        checkOutput("hitlim3_cycles", c, 3);
        checkOutput("hitlim3_status", s, 1);

        applyStimulus(17'h1ffff, 3, 3, -1, 0, 1, -1, h, c, s);
        checkOutput("both_limits_cycles", c, 3);
        checkOutput("both_limits_status", s, 1);

        applyStimulus(17'h00f0f, 0, 2, -1, 1, 1, -1, h, c, s);
        checkOutput("len0_hits", h, 0);
        checkOutput("len0_cycles", c, 0);
        checkOutput("len0_status", s, 0);

        applyStimulus(17'h15555, 10, 0, 3, 5, 0, -1, h, c, s);
        checkOutput("abort_cycles", c, 3);
        checkOutput("abort_status", s, 2);

        applyStimulus(17'h0aaaa, 300, 0, -1, 1, 1, -1, h, c, s);
        checkOutput("sat_hits", h, 255);
        checkOutput("sat_cycles", c, 300);
        checkOutput("sat_status", s, 0);

        applyStimulus(17'h13579, 300, 0, -1, 1, 1, 50, h, c, s);

        applyStimulus(17'h02468, 4, 0, -2, 1, 0, -1, h, c, s);
        checkOutput("load_abort_status", s, 2);

        for (int n = 0; n < 40; n++) begin
            len = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 0)) : int'($urandom_range(40, 0));
            hitlim = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            r = int'($urandom_range(7, 0));
            if (r == 0) abort_at = -2;
            else if (r <= 2) abort_at = int'($urandom_range(len, 0));
            else abort_at = -1;
            applyStimulus(SEL_W'($urandom), len, hitlim, abort_at,
                          int'($urandom_range(5, 0)), 0, -1, h, c, s);
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s420_scan_ctrl.md
S420_SCAN_CTRL -- requirements
Module: s420_scan_ctrl

Interface
REQ-001 Parameter SEL_W, default 17, SHALL set the width of the datapath select/compare vector.
REQ-002 Parameter LEN_W, default 16, SHALL set the width of the run-length and cycle counters.
REQ-003 Parameter HIT_W, default 8, SHALL set the width of the hit counter and hit limit.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 Ports (name  direction  width  meaning):
  CK  in  1  clock, rising edge
  RST_N  in  1  synchronous active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_sel  in  SEL_W  compare-select vector for the scan
  cmd_len  in  LEN_W  number of enabled count cycles
  cmd_hitlim  in  HIT_W  early-stop hit count; 0 = no limit
  abort  in  1  terminate an active scan
  dp_en  out  1  count enable to the counter/compare datapath
  dp_sel  out  SEL_W  select vector driven to the datapath
  dp_hit  in  1  datapath compare output for the current cycle
  rsp_valid  out  1  result available
  rsp_ready  in  1  result consumed when high with rsp_valid
  rsp_hits  out  HIT_W  saturating count of enabled cycles with dp_hit=1
  rsp_cycles  out  LEN_W  enabled cycles actually issued
  rsp_status  out  2  00 length done, 01 hit limit, 10 aborted
  busy  out  1  high in any state other than IDLE

Function
REQ-006 FSM states: IDLE, LOAD, RUN, DONE.
REQ-007 cmd_ready SHALL be high only in IDLE; handshake cmd_valid&cmd_ready SHALL register cmd_sel/cmd_len/cmd_hitlim and move to LOAD.
REQ-008 dp_sel SHALL update to the registered cmd_sel on the cycle after acceptance and hold until the next acceptance.
REQ-009 LOAD SHALL last exactly one cycle with dp_en=0; it SHALL go to DONE with status 00 if cmd_len=0, otherwise to RUN.
REQ-010 In RUN, dp_en SHALL be high every cycle, combinationally gated low when abort=1.
REQ-011 Each RUN cycle with dp_en=1 SHALL increment the cycle counter and, if dp_hit=1, the hit counter (saturating at 2^HIT_W-1).
REQ-012 RUN SHALL exit to DONE after the cycle in which the cycle count reaches cmd_len (status 00), or in which the hit count reaches a nonzero cmd_hitlim (status 01).
REQ-013 If both exit conditions occur in the same cycle, status SHALL be 01.
REQ-014 abort=1 in LOAD or RUN SHALL move to DONE next edge with status 10; that cycle SHALL not be counted; abort in IDLE/DONE SHALL be ignored.
REQ-015 In DONE rsp_valid SHALL be high and rsp_* SHALL be stable until rsp_valid&rsp_ready, then the FSM SHALL return to IDLE.
REQ-016 Counters SHALL clear on command acceptance; a new command SHALL not be accepted in the cycle of the rsp handshake.
REQ-017 Command-to-first-dp_en latency SHALL be 2 cycles (acceptance edge, LOAD).

Reset
REQ-018 With RST_N=0 at a rising CK edge: state IDLE, dp_en=0, dp_sel=0, rsp_valid=0, rsp_hits=0, rsp_cycles=0, rsp_status=00, busy=0.
REQ-019 Reset mid-RUN or mid-DONE SHALL discard the scan with no response.

Structure
REQ-020 Package s420_scan_pkg SHALL hold the FSM state enum, the rsp_status codes and default widths.
REQ-021 No sub-module is required; counters and FSM SHALL be inline, combinational gating limited to dp_en.

Verification
REQ-022 cmd_len=5, hitlim=0, dp_hit=1 on cycles 2 and 4 -> dp_en high 5 cycles, rsp_hits=2, rsp_cycles=5, status 00.
REQ-023 cmd_len=100, hitlim=3, dp_hit constant 1 -> stop after 3 enabled cycles, rsp_cycles=3, status 01.
REQ-024 cmd_len=3, hitlim=3, dp_hit=1 all cycles -> both limits on cycle 3, status 01.
REQ-025 cmd_len=0 -> no dp_en pulse, rsp_cycles=0, rsp_hits=0, status 00, rsp_valid 2 cycles after acceptance.
REQ-026 cmd_len=10, abort on 4th RUN cycle -> rsp_cycles=3, status 10; rsp_ready low 5 cycles holds all rsp fields.
REQ-027 cmd_len=300, hitlim=0, dp_hit constant 1 -> rsp_hits=255 (saturated), rsp_cycles=300; RST_N=0 mid-RUN -> reset values next edge.
